hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR, default 5, register-address width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, bubbles inserted before halting (EX, MEM, WB).
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have i_reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have i_enable  in  1  pipeline step enable (debug unit); 0 freezes pipeline.
REQ-007 SHALL have i_instr_rs_D / i_instr_rt_D  in  REG_ADDR  ID-stage source registers.
REQ-008 SHALL have i_instr_rt_E  in  REG_ADDR  EX-stage load destination.
REQ-009 SHALL have i_instr_rd_E  in  REG_ADDR  EX-stage ALU destination (after RegDst mux).
REQ-010 SHALL have i_instr_rd_M  in  REG_ADDR  MEM-stage destination.
REQ-011 SHALL have i_mem_read_E, i_reg_write_E, i_mem_read_M  in  1 each  control lines.
REQ-012 SHALL have i_branch_D, i_branch_taken_D, i_halt_D  in  1 each  ID-stage branch / taken / HALT opcode.
REQ-013 SHALL have o_stall_F  out  1  PC write disable.
REQ-014 SHALL have o_stall_D  out  1  IF/ID write disable.
REQ-015 SHALL have o_flush_D  out  1  IF/ID clear (taken branch).
REQ-016 SHALL have o_flush_E  out  1  ID/EX bubble insert.
REQ-017 SHALL have o_halted  out  1  pipeline drained and halted.
REQ-018 SHALL have o_stall_count  out  CNT_W  cycles stalled by data hazards.

Function
REQ-019 SHALL detect load-use: i_mem_read_E & rt_E!=0 & (rt_E==rs_D | rt_E==rt_D).
REQ-020 SHALL detect branch-ALU: i_branch_D & i_reg_write_E & rd_E!=0 & (rd_E==rs_D | rd_E==rt_D).
REQ-021 SHALL detect branch-load: i_branch_D & i_mem_read_M & rd_M!=0 & (rd_M==rs_D | rd_M==rt_D).
REQ-022 SHALL define hazard = OR of REQ-019..021; register 0 never causes a hazard.
REQ-023 SHALL, in RUN with hazard & i_enable, combinationally assert o_stall_F=o_stall_D=o_flush_E=1, o_flush_D=0 the same cycle.
REQ-024 SHALL stall a load feeding a branch 2 cycles (REQ-020 then REQ-021); no extra state needed.
REQ-025 SHALL, in RUN with no hazard, assert o_flush_D=i_branch_taken_D; hazard suppresses flush.
REQ-026 SHALL implement FSM RUN, DRAIN, HALTED.
REQ-027 SHALL transition RUN->DRAIN on i_halt_D & ~hazard & i_enable; halt under hazard waits (priority: hazard > halt > branch flush).
REQ-028 SHALL, in DRAIN, assert o_stall_F=o_stall_D=o_flush_E=1, count DRAIN_CYCLES enabled cycles, then go HALTED.
REQ-029 SHALL, in HALTED, assert o_stall_F=o_stall_D=1, o_flush_E=1, o_halted=1; leave only via reset.
REQ-030 SHALL, when i_enable=0 in any state, assert o_stall_F=o_stall_D=1, o_flush_D=o_flush_E=0 and hold FSM, drain counter and o_stall_count.
REQ-031 SHALL increment o_stall_count once per enabled RUN cycle with hazard, saturating at all-ones.
REQ-032 SHALL keep o_halted registered (high the cycle after DRAIN completes); others combinational from state and inputs.

Reset
REQ-033 SHALL, on i_reset=0, asynchronously enter RUN, clear drain counter and o_stall_count, o_halted=0.
REQ-034 SHALL, during reset, drive o_stall_F=o_stall_D=o_flush_D=o_flush_E=0 and ignore all inputs.
REQ-035 SHALL, on reset mid-DRAIN or in HALTED, abandon the halt; RUN on first edge after release.

Verification
REQ-036 SHALL test load-use: mem_read_E=1, rt_E=5, rs_D=5 -> 1 cycle stall_F/stall_D/flush_E=1, stall_count 0->1; rt_E=0 -> no stall.
REQ-037 SHALL test load->beq: lw $3 then beq $3,$4 -> 2 stall cycles, o_flush_D=0 both, then flush_D=1 if taken.
REQ-038 SHALL test halt: i_halt_D=1, no hazard -> 3 DRAIN cycles with flush_E=1, o_halted=1 next cycle, stays until reset.
REQ-039 SHALL test freeze: i_enable=0 during DRAIN count 1 for 4 cycles -> counter held, halt 2 enabled cycles after i_enable=1.
REQ-040 SHALL test saturation/reset: force 2^CNT_W+2 hazard cycles -> count stays 0xFFFF; i_reset low mid-DRAIN -> RUN, count 0.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard detection and halt sequencing for a 5-stage MIPS-style core.
// Detects load-use and branch-operand hazards, then drains the pipeline and halts on HALT.
module hazard_unit #(
    parameter int unsigned REG_ADDR     = 5,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [REG_ADDR-1:0] i_instr_rs_D,
    input  logic [REG_ADDR-1:0] i_instr_rt_D,
    input  logic [REG_ADDR-1:0] i_instr_rt_E,
    input  logic [REG_ADDR-1:0] i_instr_rd_E,
    input  logic [REG_ADDR-1:0] i_instr_rd_M,
    input  logic                i_mem_read_E,
    input  logic                i_reg_write_E,
    input  logic                i_mem_read_M,
    input  logic                i_branch_D,
    input  logic                i_branch_taken_D,
    input  logic                i_halt_D,
    output logic                o_stall_F,
    output logic                o_stall_D,
    output logic                o_flush_D,
    output logic                o_flush_E,
    output logic                o_halted,
    output logic [CNT_W-1:0]    o_stall_count
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } state_e;

    state_e            state_q;
    logic [DW-1:0]     drain_cnt_q;
    logic              halted_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic load_use;
    logic branch_alu;
    logic branch_load;
    logic hazard;

    // Register 0 is hardwired to zero, so it can never carry a dependence.
    assign load_use    = i_mem_read_E && (i_instr_rt_E != '0) &&
                         ((i_instr_rt_E == i_instr_rs_D) || (i_instr_rt_E == i_instr_rt_D));
    assign branch_alu  = i_branch_D && i_reg_write_E && (i_instr_rd_E != '0) &&
                         ((i_instr_rd_E == i_instr_rs_D) || (i_instr_rd_E == i_instr_rt_D));
    assign branch_load = i_branch_D && i_mem_read_M && (i_instr_rd_M != '0) &&
                         ((i_instr_rd_M == i_instr_rs_D) || (i_instr_rd_M == i_instr_rt_D));
    assign hazard      = load_use || branch_alu || branch_load;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= StRun;
            drain_cnt_q <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else if (i_enable) begin
            unique case (state_q)
                StRun: begin
                    if (hazard) begin
                        if (stall_cnt_q != '1) begin
                            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                        end
                    end else if (i_halt_D) begin
                        state_q     <= StDrain;
                        drain_cnt_q <= '0;
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DW'(1);
                    end
                end
                StHalted: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    always_comb begin
        o_stall_F = 1'b0;
        o_stall_D = 1'b0;
        o_flush_D = 1'b0;
        o_flush_E = 1'b0;
        if (!i_reset) begin
            // Quiet outputs while held in reset.
            o_stall_F = 1'b0;
        end else if (!i_enable) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hazard) begin
                        o_stall_F = 1'b1;
                        o_stall_D = 1'b1;
                        o_flush_E = 1'b1;
                    end else begin
                        // A HALT in ID takes precedence over a redirect.
                        o_flush_D = i_branch_taken_D && !i_halt_D;
                    end
                end
                StDrain, StHalted: begin
                    o_stall_F = 1'b1;
                    o_stall_D = 1'b1;
                    o_flush_E = 1'b1;
                end
                default: begin
                    o_stall_F = 1'b0;
                end
            endcase
        end
    end

    assign o_halted      = halted_q;
    assign o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: hazards, branch flush, halt drain,
// freeze, counter saturation and reset behaviour.
module tb_hazard_unit;

    localparam int unsigned REG_ADDR = 5;
    localparam int unsigned CNT_W    = 16;

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic                i_enable;
    logic [REG_ADDR-1:0] i_instr_rs_D, i_instr_rt_D, i_instr_rt_E, i_instr_rd_E, i_instr_rd_M;
    logic                i_mem_read_E, i_reg_write_E, i_mem_read_M;
    logic                i_branch_D, i_branch_taken_D, i_halt_D;
    logic                o_stall_F, o_stall_D, o_flush_D, o_flush_E, o_halted;
    logic [CNT_W-1:0]    o_stall_count;
    logic [4:0]          outs;

    int pass_cnt = 0;
    int total    = 0;

    always #5 i_clk = ~i_clk;

    hazard_unit #(
        .REG_ADDR     (REG_ADDR),
        .DRAIN_CYCLES (3),
        .CNT_W        (CNT_W)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_enable         (i_enable),
        .i_instr_rs_D     (i_instr_rs_D),
        .i_instr_rt_D     (i_instr_rt_D),
        .i_instr_rt_E     (i_instr_rt_E),
        .i_instr_rd_E     (i_instr_rd_E),
        .i_instr_rd_M     (i_instr_rd_M),
        .i_mem_read_E     (i_mem_read_E),
        .i_reg_write_E    (i_reg_write_E),
        .i_mem_read_M     (i_mem_read_M),
        .i_branch_D       (i_branch_D),
        .i_branch_taken_D (i_branch_taken_D),
        .i_halt_D         (i_halt_D),
        .o_stall_F        (o_stall_F),
        .o_stall_D        (o_stall_D),
        .o_flush_D        (o_flush_D),
        .o_flush_E        (o_flush_E),
        .o_halted         (o_halted),
        .o_stall_count    (o_stall_count)
    );

    // {stall_F, stall_D, flush_D, flush_E, halted}
    assign outs = {o_stall_F, o_stall_D, o_flush_D, o_flush_E, o_halted};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        i_enable = 1'b1;
        i_instr_rs_D = '0; i_instr_rt_D = '0;
        i_instr_rt_E = '0; i_instr_rd_E = '0; i_instr_rd_M = '0;
        i_mem_read_E = 1'b0; i_reg_write_E = 1'b0; i_mem_read_M = 1'b0;
        i_branch_D = 1'b0; i_branch_taken_D = 1'b0; i_halt_D = 1'b0;
    endtask

    task automatic load_use_5();
        i_mem_read_E = 1'b1; i_instr_rt_E = 5'd5; i_instr_rs_D = 5'd5;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Reset with noisy inputs: everything must stay quiet.
        clear_inputs();
        i_reset = 1'b0;
        load_use_5();
        i_halt_D = 1'b1; i_branch_taken_D = 1'b1;
        #22;
        check("reset_outs", 32'(outs), 32'h00);
        check("reset_count", 32'(o_stall_count), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        clear_inputs();
        tick();
        #2 check("idle_outs", 32'(outs), 32'h00);

        // Load-use on rs
        load_use_5();
        #2 check("load_use_outs", 32'(outs), 32'b11010);
        check("load_use_count_before", 32'(o_stall_count), 32'd0);
        tick();
        clear_inputs();
        #2 check("load_use_count_after", 32'(o_stall_count), 32'd1);
        check("after_load_use_outs", 32'(outs), 32'h00);

        // Register 0 never hazards
        i_mem_read_E = 1'b1;
        #2 check("r0_no_stall", 32'(outs), 32'h00);
        tick();
        check("r0_count_held", 32'(o_stall_count), 32'd1);
        clear_inputs();

        // Taken branch, no hazard
        i_branch_D = 1'b1; i_branch_taken_D = 1'b1; i_instr_rs_D = 5'd3; i_instr_rt_D = 5'd4;
        #2 check("branch_flush", 32'(outs), 32'b00100);
        tick();

        // lw $3 then beq $3,$4: two stall cycles, then flush
        i_mem_read_E = 1'b1; i_reg_write_E = 1'b1; i_instr_rt_E = 5'd3; i_instr_rd_E = 5'd3;
        #2 check("lw_beq_stall1", 32'(outs), 32'b11010);
        tick();
        i_mem_read_E = 1'b0; i_reg_write_E = 1'b0; i_instr_rt_E = '0; i_instr_rd_E = '0;
        i_mem_read_M = 1'b1; i_instr_rd_M = 5'd3;
        #2 check("lw_beq_stall2", 32'(outs), 32'b11010);
        check("lw_beq_count_mid", 32'(o_stall_count), 32'd2);
        tick();
        i_mem_read_M = 1'b0;
        #2 check("lw_beq_flush", 32'(outs), 32'b00100);
        check("lw_beq_count", 32'(o_stall_count), 32'd3);
        tick();

        // Branch-ALU on rt
        clear_inputs();
        i_branch_D = 1'b1; i_reg_write_E = 1'b1; i_instr_rd_E = 5'd7; i_instr_rt_D = 5'd7;
        #2 check("branch_alu_stall", 32'(outs), 32'b11010);
        tick();
        check("branch_alu_count", 32'(o_stall_count), 32'd4);
        clear_inputs();

        // Freeze in RUN with hazard: no count, no flush_E
        i_enable = 1'b0;
        load_use_5();
        #2 check("freeze_run_outs", 32'(outs), 32'b11000);
        tick();
        check("freeze_run_count", 32'(o_stall_count), 32'd4);
        clear_inputs();

        // Halt under hazard waits
        i_halt_D = 1'b1;
        load_use_5();
        #2 check("halt_hazard_outs", 32'(outs), 32'b11010);
        tick();
        check("halt_hazard_count", 32'(o_stall_count), 32'd5);
        clear_inputs();
        i_halt_D = 1'b1; i_branch_taken_D = 1'b1; i_branch_D = 1'b1;
        #2 check("halt_suppresses_flush", 32'(outs), 32'h00);
        tick();
        clear_inputs();

        // Three drain cycles, hazards not counted
        #2 check("drain1", 32'(outs), 32'b11010);
        tick();
        load_use_5();
        #2 check("drain2", 32'(outs), 32'b11010);
        tick();
        clear_inputs();
        #2 check("drain3", 32'(outs), 32'b11010);
        check("drain_count_held", 32'(o_stall_count), 32'd5);
        tick();
        #2 check("halted", 32'(outs), 32'b11011);
        tick(); tick(); tick();
        i_halt_D = 1'b1; i_branch_taken_D = 1'b1;
        #2 check("halted_stays", 32'(outs), 32'b11011);
        i_enable = 1'b0;
        #2 check("halted_frozen", 32'(outs), 32'b11001);
        tick();

        // Reset while halted
        i_reset = 1'b0;
        #2 check("reset_halted_outs", 32'(outs), 32'h00);
        check("reset_halted_count", 32'(o_stall_count), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        clear_inputs();
        tick();
        #2 check("run_after_reset", 32'(outs), 32'h00);

        // Freeze mid-drain after one enabled drain cycle
        i_halt_D = 1'b1;
        tick();
        clear_inputs();
        #2 check("fz_drain1", 32'(outs), 32'b11010);
        tick();
        i_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2 check("fz_frozen", 32'(outs), 32'b11000);
            tick();
        end
        i_enable = 1'b1;
        #2 check("fz_drain2", 32'(outs), 32'b11010);
        tick();
        #2 check("fz_drain3", 32'(outs), 32'b11010);
        tick();
        #2 check("fz_halted", 32'(outs), 32'b11011);

        // Saturation
        i_reset = 1'b0;
        #2;
        @(negedge i_clk);
        i_reset = 1'b1;
        tick();
        load_use_5();
        repeat (65538) @(posedge i_clk);
        #2 check("sat_count", 32'(o_stall_count), 32'h0000_FFFF);
        check("sat_outs", 32'(outs), 32'b11010);
        tick();
        clear_inputs();

        // Reset mid-drain abandons halt
        i_halt_D = 1'b1;
        #2 check("md_halt_cycle", 32'(outs), 32'h00);
        tick();
        clear_inputs();
        #2 check("md_drain1", 32'(outs), 32'b11010);
        tick();
        i_reset = 1'b0;
        #2 check("md_reset_outs", 32'(outs), 32'h00);
        check("md_reset_count", 32'(o_stall_count), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        tick();
        #2 check("md_run_idle", 32'(outs), 32'h00);
        load_use_5();
        #2 check("md_run_hazard", 32'(outs), 32'b11010);
        tick();
        clear_inputs();
        tick(); tick(); tick();
        #2 check("md_not_halted", 32'(outs), 32'h00);
        check("md_count", 32'(o_stall_count), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
